// File: rtl/riscv_ext_intc.sv
// External-interrupt front end: per-channel synchroniser, debouncer and edge
// latch, exposed as a sel/enable/write bus slave with a masked interrupt vector.
module riscv_ext_intc #(
    parameter int XLEN        = 32,
    parameter int NCH         = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DB_WIDTH    = 16,
    parameter int DB_DEFAULT  = 1000
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            sel,
    input  logic            enable,
    input  logic            write,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    input  logic [NCH-1:0]  irq_i,
    output logic [NCH-1:0]  int_o
);

    localparam logic [2:0] REG_LEVEL   = 3'd0;
    localparam logic [2:0] REG_ENABLE  = 3'd1;
    localparam logic [2:0] REG_PENDING = 3'd2;
    localparam logic [2:0] REG_RISE_EN = 3'd3;
    localparam logic [2:0] REG_FALL_EN = 3'd4;
    localparam logic [2:0] REG_DBCNT   = 3'd5;
    localparam logic [DB_WIDTH-1:0] DB_RST = DB_WIDTH'(DB_DEFAULT);

    logic [NCH-1:0]      sync_r [SYNC_STAGES];
    logic [NCH-1:0]      sync_s;
    logic [NCH-1:0]      level_r;
    logic [NCH-1:0]      level_nxt_s;
    logic [DB_WIDTH-1:0] cnt_r [NCH];
    logic [DB_WIDTH-1:0] cnt_nxt_s [NCH];
    logic [NCH-1:0]      enable_r;
    logic [NCH-1:0]      pending_r;
    logic [NCH-1:0]      pending_nxt_s;
    logic [NCH-1:0]      rise_en_r;
    logic [NCH-1:0]      fall_en_r;
    logic [NCH-1:0]      edge_s;
    logic [NCH-1:0]      clr_s;
    logic [DB_WIDTH-1:0] dbcnt_r;
    logic [XLEN-1:0]     rdata_r;
    logic [XLEN-1:0]     rd_mux_s;
    logic [2:0]          reg_sel_s;
    logic                wr_s;
    logic                rd_s;
    logic                unused_s;

    assign wr_s      = sel & enable & write;
    assign rd_s      = sel & enable & ~write;
    assign reg_sel_s = addr[4:2];
    assign sync_s    = sync_r[SYNC_STAGES-1];
    assign unused_s  = ^{addr[XLEN-1:5], addr[1:0], wdata};

    // Synchroniser shift registers, one column per channel
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= '0;
            end
        end else begin
            sync_r[0] <= irq_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    // Debounce next-state: restart on agreement, flip once the count reaches the threshold
    always_comb begin
        level_nxt_s = level_r;
        for (int i = 0; i < NCH; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (sync_s[i] == level_r[i]) begin
                cnt_nxt_s[i] = '0;
            end else if (cnt_r[i] >= dbcnt_r) begin
                level_nxt_s[i] = sync_s[i];
                cnt_nxt_s[i]   = '0;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + DB_WIDTH'(1);
            end
        end
    end

    // Debounced level and per-channel counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level_r <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            level_r <= level_nxt_s;
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Edge events latch on the same edge the debounced level flips; set beats W1C
    always_comb begin
        if (wr_s && (reg_sel_s == REG_PENDING)) begin
            clr_s = wdata[NCH-1:0];
        end else begin
            clr_s = '0;
        end
        edge_s        = (level_nxt_s & ~level_r & rise_en_r) |
                        (~level_nxt_s & level_r & fall_en_r);
        pending_nxt_s = (pending_r & ~clr_s) | edge_s;
    end

    // Software-visible control registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            enable_r  <= '0;
            rise_en_r <= '0;
            fall_en_r <= '0;
            dbcnt_r   <= DB_RST;
            pending_r <= '0;
        end else begin
            pending_r <= pending_nxt_s;
            if (wr_s) begin
                case (reg_sel_s)
                    REG_ENABLE:  enable_r  <= wdata[NCH-1:0];
                    REG_RISE_EN: rise_en_r <= wdata[NCH-1:0];
                    REG_FALL_EN: fall_en_r <= wdata[NCH-1:0];
                    REG_DBCNT:   dbcnt_r   <= wdata[DB_WIDTH-1:0];
                    default:     ;
                endcase
            end
        end
    end

    // Read mux, zero-extended; unmapped offsets read zero
    always_comb begin
        rd_mux_s = '0;
        case (reg_sel_s)
            REG_LEVEL:   rd_mux_s[NCH-1:0]      = level_r;
            REG_ENABLE:  rd_mux_s[NCH-1:0]      = enable_r;
            REG_PENDING: rd_mux_s[NCH-1:0]      = pending_r;
            REG_RISE_EN: rd_mux_s[NCH-1:0]      = rise_en_r;
            REG_FALL_EN: rd_mux_s[NCH-1:0]      = fall_en_r;
            REG_DBCNT:   rd_mux_s[DB_WIDTH-1:0] = dbcnt_r;
            default:     rd_mux_s               = '0;
        endcase
    end

    // Registered read data, held between reads
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_r <= '0;
        end else if (rd_s) begin
            rdata_r <= rd_mux_s;
        end
    end

    assign rdata = rdata_r;
    assign int_o = pending_r & enable_r;

endmodule

// File: tb/tb_riscv_ext_intc.sv
// Directed bench for riscv_ext_intc: read results go through an expected-value
// queue, interrupt timing is checked cycle by cycle.
module tb_riscv_ext_intc;

    logic        clk;
    logic        rstn;
    logic        sel;
    logic        enable;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] irq_i;
    logic [15:0] int_o;

    int          tests;
    int          fails;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    localparam logic [31:0] A_LEVEL   = 32'h00;
    localparam logic [31:0] A_ENABLE  = 32'h04;
    localparam logic [31:0] A_PENDING = 32'h08;
    localparam logic [31:0] A_RISE_EN = 32'h0C;
    localparam logic [31:0] A_FALL_EN = 32'h10;
    localparam logic [31:0] A_DBCNT   = 32'h14;
    localparam logic [31:0] A_BAD     = 32'h18;

    riscv_ext_intc #(
        .XLEN(32), .NCH(16), .SYNC_STAGES(2), .DB_WIDTH(16), .DB_DEFAULT(1000)
    ) dut (
        .clk(clk), .rstn(rstn), .sel(sel), .enable(enable), .write(write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .irq_i(irq_i), .int_o(int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        sel = 1'b1; enable = 1'b1; write = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; enable = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        sel = 1'b1; enable = 1'b1; write = 1'b0; addr = a;
        tick();
        sel = 1'b0; enable = 1'b0;
        check(tag_q.pop_front(), rdata, exp_q.pop_front());
    endtask

    initial begin
        tests = 0; fails = 0;
        rstn = 1'b0; sel = 1'b0; enable = 1'b0; write = 1'b0;
        addr = 32'h0; wdata = 32'h0; irq_i = 16'h0;
        ticks(3);
        check("reset_rdata", rdata, 32'h0);
        check("reset_int", {16'h0, int_o}, 32'h0);
        rstn = 1'b1;
        tick();
        bus_read(A_DBCNT, 32'd1000, "reset_dbcnt");
        bus_read(A_LEVEL, 32'h0, "reset_level");

        // Rise-only debounce latency: 2 sync + 4 threshold + 1
        bus_write(A_DBCNT, 32'd4);
        bus_write(A_RISE_EN, 32'h1);
        bus_write(A_ENABLE, 32'h1);
        irq_i[0] = 1'b1;
        ticks(6);
        check("rise_lat_6", {16'h0, int_o}, 32'h0);
        tick();
        check("rise_lat_7", {16'h0, int_o}, 32'h1);
        bus_read(A_LEVEL, 32'h1, "rise_level");
        bus_write(A_PENDING, 32'h1);
        check("rise_w1c_int", {16'h0, int_o}, 32'h0);

        // Glitch rejection then an accepted pulse on ch3
        bus_write(A_RISE_EN, 32'h9);
        irq_i[3] = 1'b1;
        ticks(3);
        irq_i[3] = 1'b0;
        ticks(10);
        bus_read(A_LEVEL, 32'h1, "glitch_level");
        bus_read(A_PENDING, 32'h0, "glitch_pending");
        check("glitch_int", {16'h0, int_o}, 32'h0);
        irq_i[3] = 1'b1;
        ticks(6);
        irq_i[3] = 1'b0;
        ticks(12);
        bus_read(A_PENDING, 32'h8, "pulse6_pending");
        bus_write(A_PENDING, 32'h8);
        bus_read(A_PENDING, 32'h0, "pulse6_cleared");

        // W1C on the same edge as a new rising event on ch1: set wins
        bus_write(A_RISE_EN, 32'hB);
        irq_i[1] = 1'b1;
        ticks(10);
        bus_read(A_PENDING, 32'h2, "w1c_pre_pending");
        irq_i[1] = 1'b0;
        ticks(10);
        irq_i[1] = 1'b1;
        ticks(6);
        bus_write(A_PENDING, 32'h2);
        bus_read(A_PENDING, 32'h2, "w1c_set_wins");
        bus_write(A_PENDING, 32'h2);
        bus_read(A_PENDING, 32'h0, "w1c_cleared");

        // Masked capture on ch5, then enable exposes it
        bus_write(A_ENABLE, 32'h0);
        bus_write(A_RISE_EN, 32'hFFFF);
        bus_write(A_FALL_EN, 32'hFFFF);
        irq_i[5] = 1'b1;
        ticks(10);
        irq_i[5] = 1'b0;
        ticks(12);
        bus_read(A_PENDING, 32'h20, "masked_pending");
        check("masked_int", {16'h0, int_o}, 32'h0);
        bus_write(A_ENABLE, 32'h20);
        check("masked_enable_int", {16'h0, int_o}, 32'h20);

        // DBCNT=0 with fall-only on ch2
        bus_write(A_ENABLE, 32'h0);
        bus_write(A_PENDING, 32'hFFFF);
        bus_write(A_RISE_EN, 32'h0);
        bus_write(A_FALL_EN, 32'h4);
        bus_write(A_DBCNT, 32'h0);
        irq_i[2] = 1'b1;
        ticks(5);
        bus_read(A_PENDING, 32'h0, "bypass_no_rise");
        bus_write(A_ENABLE, 32'h4);
        irq_i[2] = 1'b0;
        ticks(2);
        check("bypass_fall_2", {16'h0, int_o}, 32'h0);
        tick();
        check("bypass_fall_3", {16'h0, int_o}, 32'h4);
        bus_read(A_PENDING, 32'h4, "bypass_pending");

        // Asynchronous reset while a channel is mid-count
        bus_write(A_DBCNT, 32'd4);
        bus_read(A_ENABLE, 32'h4, "prereset_rdata");
        check("prereset_int", {16'h0, int_o}, 32'h4);
        irq_i[6] = 1'b1;
        ticks(5);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_int", {16'h0, int_o}, 32'h0);
        check("async_rst_rdata", rdata, 32'h0);
        tick();
        rstn = 1'b1;
        tick();
        bus_read(A_DBCNT, 32'd1000, "post_rst_dbcnt");
        bus_read(A_LEVEL, 32'h0, "post_rst_level");
        bus_read(A_BAD, 32'h0, "unmapped_read");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
